// File: rtl/sd_pkg.sv
// Opcodes and reader state encoding shared by the block reader and the disk manager.
package sd_pkg;

  localparam int CMD_W = 24;

  typedef enum logic [7:0] {
    OP_NONE     = 8'd0,
    OP_INIT     = 8'd1,
    OP_BLOCK    = 8'd2,
    OP_OREAD    = 8'd3,
    OP_READ     = 8'd5,
    OP_READBYTE = 8'd7,
    OP_CLOSE    = 8'd8
  } sd_opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_W,
    ST_BLK,
    ST_OPEN_W,
    ST_RD_W,
    ST_RB_W,
    ST_CLOSE_W
  } sd_state_e;

  function automatic logic [CMD_W-1:0] sd_cmd(input sd_opcode_e op, input logic [15:0] arg);
    return {op, arg};
  endfunction

  function automatic logic sd_is_wait(input sd_state_e s);
    return s inside {ST_INIT_W, ST_OPEN_W, ST_RD_W, ST_RB_W, ST_CLOSE_W};
  endfunction

endpackage

// File: rtl/sd_wait_timer.sv
// Loadable down-counter; expired_o rises in the last cycle of a TIMEOUT-cycle window (TIMEOUT >= 2).
module sd_wait_timer #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;

  // Loading one short of TIMEOUT aligns expiry with the issue cycle that triggered the load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= CW'(TIMEOUT - 1);
    end else if (count_q != '0) begin
      count_q <= count_q - CW'(1);
    end
  end

  assign expired_o = !load_i && (count_q == CW'(1));

endmodule

// File: rtl/sd_block_reader.sv
// Drives the disk manager through init or a full block read, streaming each received byte out.
module sd_block_reader
  import sd_pkg::*;
#(
  parameter int unsigned BYTES_PER_BLOCK = 512,
  parameter int unsigned TIMEOUT         = 65535,
  localparam int unsigned IDX_W = (BYTES_PER_BLOCK > 1) ? $clog2(BYTES_PER_BLOCK) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_init,
  input  logic             req_read,
  input  logic [15:0]      req_block,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       dout,
  output logic             dout_valid,
  output logic [IDX_W-1:0] dout_idx,
  output logic [CMD_W-1:0] cmd_word,
  output logic             cmd_start,
  input  logic             cmd_int,
  input  logic [CMD_W-1:0] cmd_res
);

  sd_state_e        state_q;
  logic             busy_q, done_q, err_q, dout_valid_q, cmd_start_q;
  logic [7:0]       dout_q;
  logic [IDX_W-1:0] dout_idx_q, byte_cnt_q;
  logic [CMD_W-1:0] cmd_word_q;
  logic             cmd_ok, tmr_expired;
  logic             unused_res_bits;

  // NOTE: a completion in the issue cycle cannot answer the command just issued, so it is masked.
  assign cmd_ok          = cmd_int && !cmd_start_q;
  assign unused_res_bits = ^cmd_res[23:8];

  sd_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cmd_start_q),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_idx_q   <= '0;
      byte_cnt_q   <= '0;
      cmd_word_q   <= '0;
      cmd_start_q  <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here; branches below only raise what they need.
      cmd_start_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      dout_valid_q <= 1'b0;

      if (sd_is_wait(state_q) && !cmd_ok && tmr_expired) begin
        err_q   <= 1'b1;
        busy_q  <= 1'b0;
        state_q <= ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (req_init) begin
              cmd_word_q  <= sd_cmd(OP_INIT, 16'h0);
              cmd_start_q <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= ST_INIT_W;
            end else if (req_read) begin
              cmd_word_q  <= sd_cmd(OP_BLOCK, req_block);
              cmd_start_q <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= ST_BLK;
            end
          end
          ST_BLK: begin
            cmd_word_q  <= sd_cmd(OP_OREAD, 16'h0);
            cmd_start_q <= 1'b1;
            state_q     <= ST_OPEN_W;
          end
          ST_OPEN_W: if (cmd_ok) begin
            byte_cnt_q  <= '0;
            cmd_word_q  <= sd_cmd(OP_READ, 16'h0);
            cmd_start_q <= 1'b1;
            state_q     <= ST_RD_W;
          end
          ST_RD_W: if (cmd_ok) begin
            cmd_word_q  <= sd_cmd(OP_READBYTE, 16'h0);
            cmd_start_q <= 1'b1;
            state_q     <= ST_RB_W;
          end
          ST_RB_W: if (cmd_ok) begin
            dout_q       <= cmd_res[7:0];
            dout_idx_q   <= byte_cnt_q;
            dout_valid_q <= 1'b1;
            byte_cnt_q   <= byte_cnt_q + IDX_W'(1);
            cmd_start_q  <= 1'b1;
            if (byte_cnt_q == IDX_W'(BYTES_PER_BLOCK - 1)) begin
              cmd_word_q <= sd_cmd(OP_CLOSE, 16'h0);
              state_q    <= ST_CLOSE_W;
            end else begin
              cmd_word_q <= sd_cmd(OP_READ, 16'h0);
              state_q    <= ST_RD_W;
            end
          end
          ST_INIT_W, ST_CLOSE_W: if (cmd_ok) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_idx   = dout_idx_q;
  assign cmd_word   = cmd_word_q;
  assign cmd_start  = cmd_start_q;

endmodule

// File: tb/tb_sd_block_reader.sv
// Randomised bench: a disk-manager model answers commands, a command/byte model checks every cycle.
module tb_sd_block_reader;
  import sd_pkg::*;

  localparam int BPB   = 512;
  localparam int TMO   = 200;
  localparam int IDX_W = $clog2(BPB);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_init = 1'b0, req_read = 1'b0;
  logic [15:0]      req_block = '0;
  logic             busy, done, err, dout_valid, cmd_start;
  logic [7:0]       dout;
  logic [IDX_W-1:0] dout_idx;
  logic [23:0]      cmd_word, cmd_res;
  logic             cmd_int;

  int n_checks = 0, n_fail = 0;
  int cyc = 0;

  // Expected command stream (appended by scenarios) and observation counters (compare process).
  logic [23:0] exp_cmds[$];
  int          cmd_rd = 0;
  int          n_cmd = 0, n_dout = 0, n_done = 0, n_err = 0;
  int          byte_k = 0, last_idx = 0;
  int          last_issue_cyc = 0, last_int_cyc = -10;
  logic [7:0]  exp_seed = '0;
  logic [7:0]  mute_op = '0;
  int          inject_req = 0;

  sd_block_reader #(.BYTES_PER_BLOCK(BPB), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_init(req_init), .req_read(req_read), .req_block(req_block),
    .busy(busy), .done(done), .err(err), .dout(dout), .dout_valid(dout_valid),
    .dout_idx(dout_idx), .cmd_word(cmd_word), .cmd_start(cmd_start),
    .cmd_int(cmd_int), .cmd_res(cmd_res)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t required end earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Disk manager: answers every command except BLOCK and the muted opcode after a short delay.
  initial begin : manager
    int         pend = 0;
    int         rb_k = 0;
    int         inj_ack = 0;
    logic [23:0] pend_res = '0;
    logic [7:0]  op;
    cmd_int = 1'b0;
    cmd_res = '0;
    forever begin
      @(negedge clk);
      cmd_int = 1'b0;
      if (rst) begin
        pend    = 0;
        rb_k    = 0;
        inj_ack = inject_req;
      end else begin
        if (inj_ack != inject_req) begin
          inj_ack = inject_req;
          cmd_int = 1'b1;
          cmd_res = 24'hABCDEF;
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            cmd_int      = 1'b1;
            cmd_res      = pend_res;
            last_int_cyc = cyc;
          end
        end
        if (cmd_start) begin
          op = cmd_word[23:16];
          if (op == OP_OREAD) rb_k = 0;
          if (op != OP_BLOCK && op != mute_op) begin
            pend     = (op == OP_INIT) ? 10 : int'($urandom_range(1, 3));
            pend_res = (op == OP_READBYTE) ? {16'h0, 8'(8'(rb_k) + exp_seed)} : 24'h0;
            if (op == OP_READBYTE) rb_k++;
          end
        end
      end
    end
  end

  // Compare process: commands in expected order, bytes numbered from each OREAD, pulse timing.
  initial begin : compare
    logic        prev_start = 1'b0;
    logic [23:0] prev_word  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cmd_rd     = exp_cmds.size();
        byte_k     = 0;
        prev_start = 1'b0;
        prev_word  = '0;
      end else begin
        if (cmd_start) begin
          n_cmd++;
          if (cmd_rd < exp_cmds.size()) begin
            check("cmd_word", cmd_word, exp_cmds[cmd_rd]);
            cmd_rd++;
          end else begin
            check("unexpected_cmd_start", cmd_start, 0);
          end
          if (prev_start) check("back_to_back_after_block", prev_word[23:16], OP_BLOCK);
          if (cmd_word[23:16] == OP_OREAD) byte_k = 0;
          last_issue_cyc = cyc;
        end else begin
          check("cmd_word_stable", cmd_word, prev_word);
        end
        if (dout_valid) begin
          check("dout_idx", dout_idx, byte_k);
          check("dout", dout, 8'(8'(byte_k) + exp_seed));
          last_idx = int'(dout_idx);
          byte_k++;
          n_dout++;
        end
        if (done) begin
          n_done++;
          check("done_one_cycle_after_int", cyc - last_int_cyc, 1);
          check("busy_low_at_done", busy, 0);
          check("err_low_at_done", err, 0);
        end
        if (err) begin
          n_err++;
          check("err_timeout_cycles", cyc - last_issue_cyc, TMO);
          check("busy_low_at_err", busy, 0);
        end
        prev_start = cmd_start;
        prev_word  = cmd_word;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_dout_valid"}, dout_valid, 0);
    check({tag, "_dout_idx"}, dout_idx, 0);
    check({tag, "_cmd_word"}, cmd_word, 0);
    check({tag, "_cmd_start"}, cmd_start, 0);
  endtask

  task automatic push_read_seq(input logic [15:0] blk);
    exp_cmds.push_back({OP_BLOCK, blk});
    exp_cmds.push_back({OP_OREAD, 16'h0});
    for (int i = 0; i < BPB; i++) begin
      exp_cmds.push_back({OP_READ, 16'h0});
      exp_cmds.push_back({OP_READBYTE, 16'h0});
    end
    exp_cmds.push_back({OP_CLOSE, 16'h0});
  endtask

  task automatic wait_end(input int base, input int budget);
    int k = 0;
    while ((n_done + n_err) == base && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("finished_within_budget", (n_done + n_err) != base, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_init(input bit with_read);
    int b_done = n_done, b_err = n_err, b_cmd = n_cmd, b_dout = n_dout;
    exp_cmds.push_back(24'h010000);
    req_init  = 1'b1;
    req_read  = with_read;
    req_block = 16'hBEEF;
    @(negedge clk);
    req_init = 1'b0;
    req_read = 1'b0;
    check("init_busy_after_req", busy, 1);
    if (with_read) begin
      req_read = 1'b1;
      @(negedge clk);
      req_read = 1'b0;
    end
    wait_end(b_done + b_err, 200);
    check("init_done_count", n_done - b_done, 1);
    check("init_err_count", n_err - b_err, 0);
    check("init_cmd_count", n_cmd - b_cmd, 1);
    check("init_no_bytes", n_dout - b_dout, 0);
    check("init_cmds_seen", cmd_rd, exp_cmds.size());
    check("init_busy_after", busy, 0);
  endtask

  task automatic do_read(input logic [15:0] blk, input bit spur_blk, input bit pin);
    int b_done = n_done, b_err = n_err, b_cmd = n_cmd, b_dout = n_dout;
    int qb = exp_cmds.size();
    push_read_seq(blk);
    if (pin) begin
      check("pin_first_cmd", exp_cmds[qb], 24'h021234);
      check("pin_second_cmd", exp_cmds[qb + 1], 24'h030000);
      check("pin_last_cmd", exp_cmds[exp_cmds.size() - 1], 24'h080000);
    end
    req_read  = 1'b1;
    req_block = blk;
    if (spur_blk) #1 inject_req++;
    @(negedge clk);
    req_read  = 1'b0;
    req_block = 16'hFFFF;
    check("read_busy_after_req", busy, 1);
    repeat (3) @(negedge clk);
    req_read = 1'b1;
    @(negedge clk);
    req_read = 1'b0;
    wait_end(b_done + b_err, 30000);
    check("read_done_count", n_done - b_done, 1);
    check("read_err_count", n_err - b_err, 0);
    check("read_cmd_count", n_cmd - b_cmd, 2 * BPB + 3);
    check("read_byte_count", n_dout - b_dout, BPB);
    check("read_cmds_seen", cmd_rd, exp_cmds.size());
    check("read_busy_after", busy, 0);
    if (pin) begin
      check("pin_cmd_total", n_cmd - b_cmd, 1027);
      check("pin_last_idx", last_idx, 511);
    end
  endtask

  task automatic do_timeout(input logic [7:0] mop);
    int b_done = n_done, b_err = n_err, b_cmd = n_cmd, b_dout = n_dout;
    int n_exp = (mop == OP_READBYTE) ? 4 : 2;
    exp_cmds.push_back({OP_BLOCK, 16'h00A5});
    exp_cmds.push_back({OP_OREAD, 16'h0});
    if (mop == OP_READBYTE) begin
      exp_cmds.push_back({OP_READ, 16'h0});
      exp_cmds.push_back({OP_READBYTE, 16'h0});
    end
    mute_op   = mop;
    req_read  = 1'b1;
    req_block = 16'h00A5;
    @(negedge clk);
    req_read = 1'b0;
    wait_end(b_done + b_err, 3 * TMO);
    repeat (20) @(negedge clk);
    check("tmo_err_count", n_err - b_err, 1);
    check("tmo_done_count", n_done - b_done, 0);
    check("tmo_cmd_count", n_cmd - b_cmd, n_exp);
    check("tmo_no_bytes", n_dout - b_dout, 0);
    check("tmo_cmds_seen", cmd_rd, exp_cmds.size());
    check("tmo_busy_after", busy, 0);
    mute_op = OP_NONE;
  endtask

  initial begin : main
    int b_done, b_err, b_cmd, b_dout, k;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_release");

    do_init(1'b0);
    do_init(1'b1);

    exp_seed = 8'h00;
    do_read(16'h1234, 1'b0, 1'b1);

    // Stray completions while idle must leave everything untouched.
    b_done = n_done; b_err = n_err; b_cmd = n_cmd; b_dout = n_dout;
    inject_req++;
    repeat (5) @(negedge clk);
    check("spur_idle_busy", busy, 0);
    check("spur_idle_cmds", n_cmd - b_cmd, 0);
    check("spur_idle_pulses", (n_done - b_done) + (n_err - b_err) + (n_dout - b_dout), 0);

    exp_seed = 8'($urandom);
    do_read(16'($urandom), 1'b1, 1'b0);

    do_timeout(OP_OREAD);
    do_timeout(OP_READBYTE);

    // Reset in the middle of a read, after 100 bytes have been delivered.
    b_done = n_done; b_err = n_err; b_dout = n_dout;
    exp_seed = 8'($urandom);
    push_read_seq(16'h0BAD);
    req_read  = 1'b1;
    req_block = 16'h0BAD;
    @(negedge clk);
    req_read = 1'b0;
    k = 0;
    while ((n_dout - b_dout) < 100 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check("reached_byte_100", n_dout - b_dout, 100);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_read_reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("after_mid_reset");
    check("mid_reset_no_done", n_done - b_done, 0);
    check("mid_reset_no_err", n_err - b_err, 0);

    for (int r = 0; r < 2; r++) begin
      exp_seed = 8'($urandom);
      do_read(16'($urandom), r[0], 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_block_reader.md
SD_BLOCK_READER -- requirements
Module: sd_block_reader

Interface
REQ-001 Parameter BYTES_PER_BLOCK, default 512: number of data bytes read per block.
REQ-002 Parameter TIMEOUT, default 65535: maximum cycles to wait for one command completion.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_init  input  1  one-cycle pulse: initialise card.
REQ-006 req_read  input  1  one-cycle pulse: read block req_block.
REQ-007 req_block  input  16  block number, sampled with req_read.
REQ-008 busy  output  1  high from accepted request until done/err.
REQ-009 done  output  1  one-cycle pulse: operation completed successfully.
REQ-010 err  output  1  one-cycle pulse: operation aborted on timeout.
REQ-011 dout  output  8  received data byte.
REQ-012 dout_valid  output  1  one-cycle pulse qualifying dout/dout_idx.
REQ-013 dout_idx  output  clog2(BYTES_PER_BLOCK)  byte index within block, 0-based.
REQ-014 cmd_word  output  24  command to disk manager: opcode [23:16], argument [15:0].
REQ-015 cmd_start  output  1  one-cycle pulse qualifying cmd_word.
REQ-016 cmd_int  input  1  completion pulse from disk manager.
REQ-017 cmd_res  input  24  manager result; byte in [7:0], valid with cmd_int.

Function
REQ-018 Opcodes: INIT=1, BLOCK=2, OREAD=3, READ=5, READBYTE=7, CLOSE=8; argument 0 unless stated.
REQ-019 States: IDLE, INIT_W, BLK, OPEN_W, RD_W, RB_W, CLOSE_W.
REQ-020 IDLE: req_init -> issue INIT, go INIT_W; else req_read -> latch req_block, go BLK; both same cycle -> init wins, read dropped.
REQ-021 Requests arriving while busy are ignored, no queuing.
REQ-022 BLK: issue BLOCK with arg=latched block (no completion expected); next cycle issue OREAD, go OPEN_W.
REQ-023 OPEN_W on cmd_int: clear byte counter, issue READ, go RD_W.
REQ-024 RD_W on cmd_int: issue READBYTE, go RB_W.
REQ-025 RB_W on cmd_int: dout=cmd_res[7:0], dout_idx=counter, dout_valid=1 that cycle; counter+1; if counter was BYTES_PER_BLOCK-1 issue CLOSE, go CLOSE_W; else issue READ, go RD_W.
REQ-026 INIT_W on cmd_int, CLOSE_W on cmd_int: done=1, busy=0 next cycle, go IDLE.
REQ-027 Exactly one cmd_start per issue; cmd_word held stable from issue until next issue; cmd_start never asserted in two consecutive cycles except BLOCK->OREAD.
REQ-028 cmd_int is only considered in *_W states from the cycle after the issue; cmd_int in IDLE or BLK is discarded.
REQ-029 Wait counter reloads at each issue; reaching TIMEOUT in any *_W state -> err=1, no further command, go IDLE; on READ-phase timeouts no CLOSE is sent.
REQ-030 Byte counter width clog2(BYTES_PER_BLOCK); never wraps within one block; exactly BYTES_PER_BLOCK dout_valid pulses per successful read.
REQ-031 Minimum read latency: 3 + 2*BYTES_PER_BLOCK + manager delays; done exactly one cycle after CLOSE completion.

Reset
REQ-032 On rst: state IDLE, busy=0, done=0, err=0, dout=0, dout_valid=0, dout_idx=0, cmd_word=0, cmd_start=0, counters 0.
REQ-033 rst mid-operation aborts immediately; no CLOSE sent; no done/err pulse.

Structure
REQ-034 Opcode constants and state encoding in shared package sd_pkg, also used by the disk manager.
REQ-035 One sub-module natural: sd_wait_timer (loadable down-counter with expiry flag).
REQ-036 All outputs registered.

Verification
REQ-037 req_init, manager model returns cmd_int after 10 cycles -> cmd_word=0x010000 once, done after int, busy 0.
REQ-038 req_read block 0x1234, model returns bytes i&0xFF -> command order 0x021234,0x030000,(0x050000,0x070000)x512,0x080000; 512 dout_valid with dout_idx 0..511; one done.
REQ-039 Model never answers OREAD -> err pulse exactly TIMEOUT cycles after OREAD issue, no further cmd_start, busy 0.
REQ-040 req_init and req_read same cycle -> INIT only; req_read during busy -> ignored, no extra commands.
REQ-041 rst asserted at byte 100 -> all outputs 0 immediately; new req_read afterwards completes normally from byte 0.
REQ-042 Spurious cmd_int in IDLE and during BLK -> no state change, no output pulses.
